// File: rtl/cke_tick_scheduler.sv
// cke_tick_scheduler: one shared base prescaler driving per-channel one-shot/periodic clock enables
module cke_tick_scheduler #(
  parameter int pChNum    = 4,
  parameter int pDivWidth = 16,
  parameter int pCntWidth = 8,
  parameter int pChIdW    = 2
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_ni,
  input  logic [pDivWidth-1:0] div_i,
  input  logic                 pre_en_i,
  input  logic                 cfg_vd_i,
  output logic                 cfg_rdy_o,
  input  logic [pChIdW-1:0]    cfg_ch_i,
  input  logic [pCntWidth-1:0] cfg_period_i,
  input  logic                 cfg_mode_i,
  input  logic [pChNum-1:0]    ch_stop_i,
  output logic                 base_cke_o,
  output logic [pChNum-1:0]    ch_cke_o,
  output logic [pChNum-1:0]    ch_busy_o
);
  localparam logic [pDivWidth-1:0] DIV_ONE = {{(pDivWidth-1){1'b0}}, 1'b1};
  localparam logic [pCntWidth-1:0] CNT_ONE = {{(pCntWidth-1){1'b0}}, 1'b1};
  logic [pDivWidth-1:0] pre_q, pre_d;
  logic                 rdy_q, rdy_d, commit_q, commit_d;
  logic [pChIdW-1:0]    pend_ch_q, pend_ch_d;
  logic [pCntWidth-1:0] pend_per_q, pend_per_d;
  logic                 pend_mode_q, pend_mode_d;
  logic [pCntWidth-1:0] per_q [pChNum];
  logic [pCntWidth-1:0] per_d [pChNum];
  logic [pCntWidth-1:0] cnt_q [pChNum];
  logic [pCntWidth-1:0] cnt_d [pChNum];
  logic [pChNum-1:0]    mode_q, mode_d, run_q, run_d, cke_q, cke_d;
  logic [pChNum-1:0]    hit, term;
  logic                 tick, accept;
  assign tick       = pre_en_i & (pre_q == div_i);
  assign accept     = cfg_vd_i & rdy_q;
  assign cfg_rdy_o  = rdy_q;
  assign base_cke_o = tick & sys_rst_ni;
  assign ch_cke_o   = cke_q;
  assign ch_busy_o  = run_q;
  // prescaler advance and config capture; ready drops for the commit cycle after each accept
  always_comb begin
    pre_d       = tick ? '0 : pre_en_i ? pre_q + DIV_ONE : pre_q;
    rdy_d       = ~accept;
    commit_d    = accept;
    pend_ch_d   = accept ? cfg_ch_i : pend_ch_q;
    pend_per_d  = accept ? ((cfg_period_i == '0) ? CNT_ONE : cfg_period_i) : pend_per_q;
    pend_mode_d = accept ? cfg_mode_i : pend_mode_q;
  end
  // per-channel next state: stop beats commit, commit beats a coincident base tick
  always_comb begin
    hit    = '0;
    term   = '0;
    per_d  = per_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    run_d  = run_q;
    cke_d  = '0;
    for (int i = 0; i < pChNum; i++) begin
      hit[i]    = commit_q & (pend_ch_q == pChIdW'(i));
      term[i]   = run_q[i] & tick & ~ch_stop_i[i] & ~hit[i] & (cnt_q[i] == per_q[i] - CNT_ONE);
      per_d[i]  = hit[i] ? pend_per_q : per_q[i];
      mode_d[i] = hit[i] ? pend_mode_q : mode_q[i];
      run_d[i]  = ch_stop_i[i] ? 1'b0 : hit[i] ? 1'b1 : (term[i] & ~mode_q[i]) ? 1'b0 : run_q[i];
      cnt_d[i]  = (ch_stop_i[i] | hit[i] | term[i]) ? '0 :
                  (run_q[i] & tick) ? cnt_q[i] + CNT_ONE : cnt_q[i];
      cke_d[i]  = term[i];
    end
  end
  // state registers, cleared asynchronously
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pre_q       <= '0;
      rdy_q       <= 1'b0;
      commit_q    <= 1'b0;
      pend_ch_q   <= '0;
      pend_per_q  <= '0;
      pend_mode_q <= 1'b0;
      mode_q      <= '0;
      run_q       <= '0;
      cke_q       <= '0;
      for (int i = 0; i < pChNum; i++) begin
        per_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pre_q       <= pre_d;
      rdy_q       <= rdy_d;
      commit_q    <= commit_d;
      pend_ch_q   <= pend_ch_d;
      pend_per_q  <= pend_per_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      cke_q       <= cke_d;
      for (int i = 0; i < pChNum; i++) begin
        per_q[i] <= per_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_cke_tick_scheduler.sv
// tb_cke_tick_scheduler: directed vector table plus hand sequences for stop/commit, handshake and reset
module tb_cke_tick_scheduler;
  typedef struct {
    logic [15:0] div;
    logic        en;
    logic        vd;
    logic [2:0]  ch;
    logic [7:0]  per;
    logic        md;
    logic [3:0]  stp;
    logic        rdy;
    logic        bs;
    logic [3:0]  ck;
    logic [3:0]  bz;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic        pre_en, cfg_vd, cfg_md;
  logic [2:0]  cfg_ch;
  logic [7:0]  cfg_per;
  logic [3:0]  stop;
  logic        cfg_rdy, base;
  logic [3:0]  cke, busy;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [43];
  cke_tick_scheduler #(.pChNum(4), .pDivWidth(16), .pCntWidth(8), .pChIdW(3)) dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n), .div_i(div), .pre_en_i(pre_en),
    .cfg_vd_i(cfg_vd), .cfg_rdy_o(cfg_rdy), .cfg_ch_i(cfg_ch), .cfg_period_i(cfg_per),
    .cfg_mode_i(cfg_md), .ch_stop_i(stop), .base_cke_o(base), .ch_cke_o(cke), .ch_busy_o(busy)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [15:0] d, input logic en, input logic vd,
                              input logic [2:0] ch, input logic [7:0] per, input logic md,
                              input logic [3:0] stp, input logic rdy, input logic bs,
                              input logic [3:0] ck, input logic [3:0] bz);
    vec_t v;
    v.div = d; v.en = en; v.vd = vd; v.ch = ch; v.per = per; v.md = md; v.stp = stp;
    v.rdy = rdy; v.bs = bs; v.ck = ck; v.bz = bz;
    return v;
  endfunction
  function automatic vec_t ex(input logic [15:0] d, input logic en, input logic rdy,
                              input logic bs, input logic [3:0] ck, input logic [3:0] bz);
    return mk(d, en, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, rdy, bs, ck, bz);
  endfunction
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input bit chk_en, input string nm);
    div = v.div; pre_en = v.en; cfg_vd = v.vd; cfg_ch = v.ch;
    cfg_per = v.per; cfg_md = v.md; stop = v.stp;
    #4;
    if (chk_en) begin
      chk({nm, ".rdy"}, {3'b0, cfg_rdy}, {3'b0, v.rdy});
      chk({nm, ".base"}, {3'b0, base}, {3'b0, v.bs});
      chk({nm, ".cke"}, cke, v.ck);
      chk({nm, ".busy"}, busy, v.bz);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b1; div = 16'd0; pre_en = 1'b1; cfg_vd = 1'b0; cfg_ch = 3'd0;
    cfg_per = 8'd0; cfg_md = 1'b0; stop = 4'h0;
    // base tick spacing, freeze while disabled including freeze at the terminal count
    tbl[0]  = ex(3, 1, 0, 0, 0, 0); tbl[1]  = ex(3, 1, 1, 0, 0, 0);
    tbl[2]  = ex(3, 1, 1, 0, 0, 0); tbl[3]  = ex(3, 1, 1, 1, 0, 0);
    tbl[4]  = ex(3, 1, 1, 0, 0, 0); tbl[5]  = ex(3, 1, 1, 0, 0, 0);
    tbl[6]  = ex(3, 1, 1, 0, 0, 0); tbl[7]  = ex(3, 1, 1, 1, 0, 0);
    tbl[8]  = ex(3, 0, 1, 0, 0, 0); tbl[9]  = ex(3, 0, 1, 0, 0, 0);
    tbl[10] = ex(3, 1, 1, 0, 0, 0); tbl[11] = ex(3, 1, 1, 0, 0, 0);
    tbl[12] = ex(3, 1, 1, 0, 0, 0); tbl[13] = ex(3, 0, 1, 0, 0, 0);
    tbl[14] = ex(3, 0, 1, 0, 0, 0); tbl[15] = ex(3, 1, 1, 1, 0, 0);
    // ch0 periodic, period 3, div 1: pulse every 6 cycles one cycle after base
    tbl[16] = mk(1, 1, 1, 0, 3, 1, 0, 1, 0, 0, 0);
    tbl[17] = ex(1, 1, 0, 1, 0, 0); tbl[18] = ex(1, 1, 1, 0, 0, 1);
    tbl[19] = ex(1, 1, 1, 1, 0, 1); tbl[20] = ex(1, 1, 1, 0, 0, 1);
    tbl[21] = ex(1, 1, 1, 1, 0, 1); tbl[22] = ex(1, 1, 1, 0, 0, 1);
    tbl[23] = ex(1, 1, 1, 1, 0, 1); tbl[24] = ex(1, 1, 1, 0, 1, 1);
    tbl[25] = ex(1, 1, 1, 1, 0, 1); tbl[26] = ex(1, 1, 1, 0, 0, 1);
    tbl[27] = ex(1, 1, 1, 1, 0, 1); tbl[28] = ex(1, 1, 1, 0, 0, 1);
    tbl[29] = ex(1, 1, 1, 1, 0, 1); tbl[30] = ex(1, 1, 1, 0, 1, 1);
    // ch1 one-shot, period 2 alongside ch0
    tbl[31] = mk(1, 1, 1, 1, 2, 0, 0, 1, 1, 0, 1);
    tbl[32] = ex(1, 1, 0, 0, 0, 1); tbl[33] = ex(1, 1, 1, 1, 0, 3);
    tbl[34] = ex(1, 1, 1, 0, 0, 3); tbl[35] = ex(1, 1, 1, 1, 0, 3);
    tbl[36] = ex(1, 1, 1, 0, 3, 1); tbl[37] = ex(1, 1, 1, 1, 0, 1);
    tbl[38] = ex(1, 1, 1, 0, 0, 1); tbl[39] = ex(1, 1, 1, 1, 0, 1);
    tbl[40] = ex(1, 1, 1, 0, 0, 1); tbl[41] = ex(1, 1, 1, 1, 0, 1);
    tbl[42] = ex(1, 1, 1, 0, 1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.rdy", {3'b0, cfg_rdy}, 4'h0);
    chk("rst.base", {3'b0, base}, 4'h0);
    chk("rst.cke", cke, 4'h0);
    chk("rst.busy", busy, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    div = 16'd3;
    rst_n = 1'b1;
    for (int i = 0; i < 43; i++) step(tbl[i], 1'b1, $sformatf("t%0d", i));
    // stop suppresses terminal; stop+commit on ch2 leaves it idle; period 0 fires every tick
    step(mk(1, 1, 0, 0, 0, 0, 4'h1, 1, 1, 0, 1), 1'b1, "s43");
    step(mk(1, 1, 1, 2, 3, 1, 4'h0, 1, 0, 0, 0), 1'b1, "s44");
    step(ex(1, 1, 0, 1, 0, 0), 1'b1, "s45");
    step(ex(1, 1, 1, 0, 0, 4), 1'b1, "s46");
    step(ex(1, 1, 1, 1, 0, 4), 1'b1, "s47");
    step(mk(1, 1, 1, 2, 5, 1, 4'h4, 1, 0, 0, 4), 1'b1, "s48");
    step(mk(1, 1, 0, 0, 0, 0, 4'h4, 0, 1, 0, 0), 1'b1, "s49");
    step(ex(1, 1, 1, 0, 0, 0), 1'b1, "s50");
    step(mk(1, 1, 1, 2, 0, 1, 4'h0, 1, 1, 0, 0), 1'b1, "s51");
    step(ex(1, 1, 0, 0, 0, 0), 1'b1, "s52");
    step(ex(1, 1, 1, 1, 0, 4), 1'b1, "s53");
    step(ex(1, 1, 1, 0, 4, 4), 1'b1, "s54");
    step(ex(1, 1, 1, 1, 0, 4), 1'b1, "s55");
    step(ex(1, 1, 1, 0, 4, 4), 1'b1, "s56");
    step(mk(1, 1, 0, 0, 0, 0, 4'h4, 1, 1, 0, 4), 1'b1, "s57");
    // back-to-back valid: out-of-range channel discarded, second write two cycles later
    step(mk(1, 1, 1, 5, 1, 1, 4'h0, 1, 0, 0, 0), 1'b1, "s58");
    step(mk(1, 1, 1, 0, 1, 1, 4'h0, 0, 1, 0, 0), 1'b1, "s59");
    step(mk(1, 1, 1, 0, 1, 1, 4'h0, 1, 0, 0, 0), 1'b1, "s60");
    step(ex(1, 1, 0, 1, 0, 0), 1'b1, "s61");
    step(ex(1, 1, 1, 0, 0, 1), 1'b1, "s62");
    step(ex(1, 1, 1, 1, 0, 1), 1'b1, "s63");
    step(ex(1, 1, 1, 0, 1, 1), 1'b1, "s64");
    // start ch1..ch3, then async reset mid-cycle with all channels running
    for (int c = 1; c < 4; c++) begin
      step(mk(1, 1, 1, 3'(c), 3, 1, 4'h0, 0, 0, 0, 0), 1'b0, "w");
      step(ex(1, 1, 0, 0, 0, 0), 1'b0, "w");
    end
    #4;
    chk("all_busy", busy, 4'hf);
    #1;
    div = 16'd0;
    rst_n = 1'b0;
    #1;
    chk("arst.rdy", {3'b0, cfg_rdy}, 4'h0);
    chk("arst.base", {3'b0, base}, 4'h0);
    chk("arst.cke", cke, 4'h0);
    chk("arst.busy", busy, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(ex(0, 1, 0, 1, 0, 0), 1'b1, "r0");
    for (int i = 1; i < 16; i++) step(ex(0, 1, 1, 1, 0, 0), 1'b1, $sformatf("r%0d", i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
